// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for a bank of common-segment 7-segment
// digits. One BCD-to-7-segment decoder is shared across all digits. The host
// loads a display word at any time. The word is held in a pending register and
// moves to the displayed (shadow) register only at a frame boundary, so a frame
// never mixes old and new digits. Each digit slot opens with a short blanked
// guard interval, which keeps the previous digit from ghosting onto the next.
//
// Parameters:
//   NUM_DIGITS   - number of digits scanned (>= 1)
//   REFRESH_DIV  - clock cycles per digit slot (>= 2)
//   BLANK_CYCLES - blanked guard cycles at slot start (1 .. REFRESH_DIV-1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   scan enable; 0 = display off
//   load       in   one-cycle strobe; capture digits_in / dp_in
//   digits_in  in   BCD digits, [3:0] = digit 0 (least significant)
//   dp_in      in   decimal point per digit
//   seg        out  {a,b,c,d,e,f,g}, active-high, registered
//   dp         out  decimal point of the active digit, registered
//   an         out  one-hot digit enable, active-high, registered
//   frame_done out  one-cycle pulse on the last cycle of each full frame
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, in the show phase a digit k > 0 has its segments blanked if
//   shadow digits k..NUM_DIGITS-1 are all zero. an and dp are still driven.
//   Digit 0 is never suppressed. When undefined, every digit is decoded as-is.
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Digit vectors are kept as packed 2-D arrays so a digit index selects a
    // whole BCD nibble.
    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    digits_t                 shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    digits_t                 pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    // High on the edge where the displayed word may change: the IDLE->SCAN
    // entry edge, or the last cycle of a frame.
    logic                    boundary;

    // Per-digit segment pattern from the current shadow word.
    logic [NUM_DIGITS-1:0][6:0] digit_seg;

    // -------------------------------------------------------------------------
    // Shared BCD decoder. Values 10..15 are not BCD and light nothing.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic zeros_above;
`endif

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_seg[k] = bcd_to_seg(shadow_q[k]);
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the most significant digit; once a non-zero digit is
        // seen, every lower digit is significant and keeps its segments.
        zeros_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zeros_above = zeros_above && (shadow_q[k] == 4'd0);
            if (zeros_above) begin
                digit_seg[k] = 7'b0000000;
            end
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        boundary     = 1'b0;
        seg_d        = 7'b0000000;
        dp_d         = 1'b0;
        an_d         = '0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d  = ST_SCAN;
                    cnt_d    = '0;
                    idx_d    = '0;
                    boundary = 1'b1;
                end
            end

            ST_SCAN: begin
                if (!en) begin
                    // Dropping enable abandons the frame. The next enable
                    // restarts at digit 0 with its blank phase.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end

                    frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
                    boundary     = frame_done_d;

                    // Outputs follow the slot position being entered on this
                    // edge. shadow_q only changes on a boundary edge, and that
                    // edge still shows the old word, so the frame stays whole.
                    if (cnt_d >= CNT_SHOW) begin
                        an_d[idx_d] = 1'b1;
                        seg_d       = digit_seg[idx_d];
                        dp_d        = shadow_dp_q[idx_d];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Host load path: the pending register collects the latest load, and the
    // shadow register takes it at the next boundary. A load on the boundary
    // edge itself goes straight to shadow.
    // -------------------------------------------------------------------------
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_vld_d  = pend_vld_q;

        if (boundary) begin
            if (load) begin
                shadow_d    = digits_t'(digits_in);
                shadow_dp_d = dp_in;
                pend_vld_d  = 1'b0;
            end else if (pend_vld_q) begin
                shadow_d    = pend_q;
                shadow_dp_d = pend_dp_q;
                pend_vld_d  = 1'b0;
            end
        end else if (load) begin
            pend_d     = digits_t'(digits_in);
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            // NOTE: the display word registers are reset along with the
            // control state, so a display re-enabled after reset shows zeros
            // and never stale or pending data.
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= 7'b0000000;
            dp_q         <= 1'b0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//
// Scoreboard bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. The stimulus process drives one clock cycle at a time and
// pushes the expected {an, seg, dp, frame_done} for that edge into a queue.
// A separate monitor samples the outputs 1 ns after each rising edge, pops the
// head of the queue and compares. Expected frames come from a hand-written
// segment table and the slot layout: 8 cycles per digit, 2 blank, 6 shown.
// When LEADING_ZERO_BLANK_EN is defined the expectations blank leading zeros.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    typedef struct packed {
        logic [15:0]   tag;
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dp;
        logic          fd;
    } obs_t;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            load;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0]   dp_in;
    logic [6:0]      seg;
    logic            dp;
    logic [ND-1:0]   an;
    logic            frame_done;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for position c (0-based) of a frame showing word d.
    function automatic obs_t frame_exp(input logic [15:0] d, input logic [3:0] p, input int c);
        obs_t o;
        int   di;
        int   ci;
        o  = '0;
        di = c / RD;
        ci = c % RD;
        o.fd = (c == FRAME - 1);
        if (ci >= BC) begin
            o.an[di] = 1'b1;
            o.seg    = SEG_TAB[d[di*4 +: 4]];
            o.dp     = p[di];
`ifdef LEADING_ZERO_BLANK_EN
            if (di > 0 && (d >> (di * 4)) == 16'h0000) o.seg = 7'b0000000;
`endif
        end
        return o;
    endfunction

    // One clock cycle: set inputs for the coming edge, queue its expectation.
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [15:0] d, input logic [3:0] p, input obs_t x);
        @(negedge clk);
        rst_n     = r;
        en        = e;
        load      = l;
        digits_in = d;
        dp_in     = p;
        cyc_no++;
        x.tag = 16'(cyc_no);
        exp_q.push_back(x);
    endtask

    // n cycles of scanning with word sd displayed; optional load on cycle
    // load_at (1-based within the frame, 0 = none).
    task automatic run_frame(input logic [15:0] sd, input logic [3:0] sp, input int n,
                             input int load_at, input logic [15:0] ld, input logic [3:0] lp);
        for (int c = 0; c < n; c++) begin
            if (c + 1 == load_at) step(1'b1, 1'b1, 1'b1, ld, lp, frame_exp(sd, sp, c));
            else                  step(1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, frame_exp(sd, sp, c));
        end
    endtask

    // Monitor: compares every edge for which an expectation was queued.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({an, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                    failures++;
                    $display("FAIL out_cyc%0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                             e.tag, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;

        // Reset, then load 0x4321 while idle.
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, obs_t'(0));
        step(1'b1, 1'b0, 1'b1, 16'h4321, 4'b0000, obs_t'(0));

        // Frame 1 shows 4321; load 0x9999 at cycle 12 stays pending.
        run_frame(16'h4321, 4'b0000, FRAME, 12, 16'h9999, 4'b0000);
        // Frame 2 shows 9999; load 0x0007 on the frame_done edge.
        run_frame(16'h9999, 4'b0000, FRAME, FRAME, 16'h0007, 4'b0001);
        // Frame 3 shows 0007; invalid-BCD word loaded mid-frame.
        run_frame(16'h0007, 4'b0001, FRAME, 5, 16'hFA5B, 4'b1010);
        // Frame 4 shows FA5B.
        run_frame(16'hFA5B, 4'b1010, FRAME, 0, 16'h0000, 4'h0);

        // Enable drop at cycle 13 of frame 5, then load while idle.
        run_frame(16'hFA5B, 4'b1010, 12, 0, 16'h0000, 4'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, obs_t'(0));
        step(1'b1, 1'b0, 1'b1, 16'h0120, 4'b0001, obs_t'(0));
        step(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, obs_t'(0));
        // Re-enable: restarts at digit 0 blank phase with the idle load.
        run_frame(16'h0120, 4'b0001, FRAME, 0, 16'h0000, 4'h0);

        // Reset mid-scan at cycle 20, with a pending load it must discard.
        run_frame(16'h0120, 4'b0001, 19, 15, 16'h5555, 4'b1111);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, obs_t'(0));
        step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, obs_t'(0));
        run_frame(16'h0000, 4'b0000, FRAME, 0, 16'h0000, 4'h0);

        step(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, obs_t'(0));
        step(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, obs_t'(0));

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d queued expectations left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-segment 7-segment digits. It shares one BCD-to-7-segment decode path across NUM_DIGITS digits. It latches a display word from the host and updates it tear-free at frame boundaries. Each digit slot starts with a ghosting guard of blanked cycles. It sits between the host/counter logic and the board-level segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
REFRESH_DIV, 1000, clock cycles per digit slot (>=2)
BLANK_CYCLES, 2, blanked guard cycles at the start of each slot (1 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  scan enable; 0 = display off
load  input  1  one-cycle strobe; capture digits_in/dp_in
digits_in  input  4*NUM_DIGITS  BCD digits; [3:0] = digit 0 (least significant)
dp_in  input  NUM_DIGITS  decimal point per digit
seg  output  7  {a,b,c,d,e,f,g}, active-high, registered
dp  output  1  decimal point of the active digit, registered
an  output  NUM_DIGITS  one-hot digit enable, active-high, registered
frame_done  output  1  one-cycle pulse at end of each full frame

Behaviour:
- Reset: rst_n=0 sampled on a clk edge. Clears seg, dp, an and frame_done to 0. Clears shadow and pending registers, the pending flag, slot counter cnt and digit index idx to 0. State becomes IDLE. Reset mid-scan aborts immediately.
- Decode (digit 0-9): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Decode (values 10-15): seg=0000000.
- States:
  - IDLE: outputs all 0.
  - IDLE -> SCAN on an edge sampling en=1, with cnt=0 and idx=0.
  - SCAN -> IDLE on any edge sampling en=0. cnt and idx clear; outputs go 0 on that edge.
- Slot timing in SCAN: cnt counts 0..REFRESH_DIV-1. On wrap, idx increments, and wraps NUM_DIGITS-1 -> 0.
- Registered outputs per edge:
  - Blank phase, cnt<BLANK_CYCLES: an=0, seg=0, dp=0.
  - Show phase, otherwise: an=1<<idx, seg=decode(shadow[idx]), dp=shadow_dp[idx].
- First-frame timing: the first edge sampling en=1 yields BLANK_CYCLES blank cycles, then digit 0 shown for REFRESH_DIV-BLANK_CYCLES cycles. Frame length = NUM_DIGITS*REFRESH_DIV cycles.
- frame_done: 1 for exactly the edge where cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1. Never asserted in IDLE.
- load:
  - Captures digits_in/dp_in into pending and sets the pending flag. The latest load before a boundary wins.
  - Frame boundary = the frame_done edge, or the IDLE->SCAN edge. If pending, shadow <= pending and the flag clears.
  - A load coincident with a boundary writes directly to shadow, effective in the next frame.
  - load is accepted in IDLE; the value appears at the next SCAN entry.
- No mid-frame change of the displayed value, ever.
- en toggled mid-slot: no partial frame resume; restart at digit 0 blank phase.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: during show phase, digit k>0 is blanked (seg=0; an still asserted; dp still driven) when shadow digits k..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed.
- Undefined: all digits are decoded as-is.

Test Plan:
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset and first frame:
   - rst_n=0 for 3 cycles, then rst_n=1, en=1, with load of 0x4321 and dp_in=4'b0000 in the prior IDLE cycle.
   - Cycles 1-2: an=0000, seg=0.
   - Cycles 3-8: an=0001, seg=0110000.
   - Cycles 9-10: blank; cycles 11-16: an=0010, seg=1101101.
   - frame_done high only at cycle 32.
2. Tear-free update: load 0x9999 at cycle 12 of frame 1. Digits 2-3 still show 3 and 4. 9s (1111011) appear from frame 2, digit 0.
3. Boundary coincidence:
   - load 0x0007 on the frame_done edge -> the next frame shows 7 (1110000) on digit 0, 0 (1111110) on digits 1-3.
   - With LEADING_ZERO_BLANK_EN: digits 1-3 show seg=0.
4. Invalid BCD: digits_in=0xFA5B -> digits 0, 2 and 3 show seg=0; digit 1 shows 5 (1011011). an still scans.
5. Enable drop: en=0 at cycle 13 -> next edge an=0, seg=0, no frame_done. en=1 again -> 2 blank cycles, then digit 0.
6. Reset mid-scan: rst_n=0 at cycle 20 -> next edge all outputs 0. Shadow cleared: after rst_n=1, en=1, digit 0 shows 1111110.
